// File: rtl/frogger_game_state_pkg.sv
// -----------------------------------------------------------------------------
// frogger_game_state_pkg
// Shared definitions for the Frogger game-state controller: FSM state codes
// (also decoded by the display and audio blocks from o_State), default
// parameter values, the frame-counter width and a saturating level helper.
// -----------------------------------------------------------------------------
package frogger_game_state_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int unsigned LP_LIVES        = 3;
    localparam int unsigned LP_DEATH_FRAMES = 30;
    localparam int unsigned LP_GOAL_ROW     = 0;
    localparam int unsigned LP_MAX_LEVEL    = 9;
    localparam int unsigned LP_COUNT_W      = 6;

    // Next level value, holding once the ceiling is reached.
    function automatic logic [3:0] level_inc(input logic [3:0] level,
                                             input logic [3:0] level_max);
        return (level >= level_max) ? level : level + 4'd1;
    endfunction

endpackage

// File: rtl/frogger_game_state_frame_timer.sv
// -----------------------------------------------------------------------------
// frogger_game_state_frame_timer
// Counts frame ticks for the death pause and the level-up pause.
// Ports:
//   i_Clk      - system clock
//   i_Reset    - synchronous active-high reset
//   i_Clear    - hold the count at zero (asserted whenever no pause is running)
//   i_Tick     - one-cycle frame pulse
//   i_Terminal - tick count that ends the pause
//   o_Done     - pulse in the cycle of the tick that reaches i_Terminal
// -----------------------------------------------------------------------------
module frogger_game_state_frame_timer
    import frogger_game_state_pkg::*;
(
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Clear,
    input  logic                  i_Tick,
    input  logic [LP_COUNT_W-1:0] i_Terminal,
    output logic                  o_Done
);

    logic [LP_COUNT_W-1:0] r_count;
    logic [LP_COUNT_W-1:0] w_count_next;

    assign w_count_next = r_count + LP_COUNT_W'(1);

    // Done is decoded from the tick itself so the owning FSM leaves its pause
    // on the very edge that would store the terminal count.
    assign o_Done = i_Tick && !i_Clear && (w_count_next == i_Terminal);

    // NOTE: reset is synchronous, so it lives inside the clocked block and is
    // tested first; a tick arriving together with reset is simply dropped.
    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Clear) begin
            r_count <= '0;
        end else if (i_Tick) begin
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/frogger_game_state.sv
// -----------------------------------------------------------------------------
// frogger_game_state
// Game-state controller between collision detection and frog movement.
// Owns lives, level, the death pause and game over; tells frog movement when
// to freeze and when to snap back to the spawn tile.
// Ports:
//   i_Clk, i_Reset     - clock, synchronous active-high reset
//   i_Frame_Tick       - one-cycle pulse per video frame
//   i_Start            - one-cycle start pulse (IDLE / GAME_OVER only)
//   i_Collided         - frog overlaps a car (honoured in PLAY only)
//   i_Frogger_Y        - current frog row
//   o_State            - FSM state code (state_t)
//   o_Lives, o_Level   - remaining lives, current level
//   o_Respawn          - first cycle of every PLAY entry
//   o_Freeze           - high whenever not in PLAY
//   o_Game_Over        - high in GAME_OVER
// All outputs are registered.
// -----------------------------------------------------------------------------
module frogger_game_state
    import frogger_game_state_pkg::*;
#(
    parameter int unsigned c_LIVES        = LP_LIVES,
    parameter int unsigned c_DEATH_FRAMES = LP_DEATH_FRAMES,
    parameter int unsigned c_GOAL_ROW     = LP_GOAL_ROW,
    parameter int unsigned c_MAX_LEVEL    = LP_MAX_LEVEL
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Frame_Tick,
    input  logic       i_Start,
    input  logic       i_Collided,
    input  logic [5:0] i_Frogger_Y,
    output logic [2:0] o_State,
    output logic [1:0] o_Lives,
    output logic [3:0] o_Level,
    output logic       o_Respawn,
    output logic       o_Freeze,
    output logic       o_Game_Over
);

    state_t                r_state;
    logic [1:0]            r_lives;
    logic [3:0]            r_level;
    logic                  r_respawn;
    logic                  r_guard;
    logic                  r_freeze;
    logic                  r_game_over;

    logic                  w_counting;
    logic [LP_COUNT_W-1:0] w_terminal;
    logic                  w_timer_done;
    logic                  w_collision;
    logic                  w_goal;

    // One timer serves both pauses; it is held clear outside them, so it
    // always starts from zero on entry.
    assign w_counting = (r_state == ST_DYING) || (r_state == ST_LEVEL_UP);
    assign w_terminal = (r_state == ST_LEVEL_UP) ? LP_COUNT_W'(1)
                                                 : LP_COUNT_W'(c_DEATH_FRAMES);

    // The respawn cycle and the one after it are ignored: the frog position
    // register has not yet reloaded, so the collision flag is stale.
    assign w_collision = (r_state == ST_PLAY) && i_Collided && !r_respawn && !r_guard;
    assign w_goal      = (r_state == ST_PLAY) && (i_Frogger_Y == 6'(c_GOAL_ROW));

    frogger_game_state_frame_timer u_frame_timer (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Clear    (!w_counting),
        .i_Tick     (i_Frame_Tick),
        .i_Terminal (w_terminal),
        .o_Done     (w_timer_done)
    );

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values; the defaults at the top of the
    // else branch are overridden by the case items below.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state     <= ST_IDLE;
            r_lives     <= 2'(c_LIVES);
            r_level     <= '0;
            r_respawn   <= 1'b0;
            r_guard     <= 1'b0;
            r_freeze    <= 1'b1;
            r_game_over <= 1'b0;
        end else begin
            r_respawn <= 1'b0;
            r_guard   <= r_respawn;
            case (r_state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (i_Start) begin
                        r_state     <= ST_PLAY;
                        r_lives     <= 2'(c_LIVES);
                        r_level     <= '0;
                        r_respawn   <= 1'b1;
                        r_freeze    <= 1'b0;
                        r_game_over <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    // Collision is tested first so it wins a simultaneous goal.
                    if (w_collision) begin
                        r_state  <= ST_DYING;
                        r_freeze <= 1'b1;
                        if (r_lives != 2'd0) begin
                            r_lives <= r_lives - 2'd1;
                        end
                    end else if (w_goal) begin
                        r_state  <= ST_LEVEL_UP;
                        r_freeze <= 1'b1;
                        r_level  <= level_inc(r_level, 4'(c_MAX_LEVEL));
                    end
                end
                ST_DYING: begin
                    if (w_timer_done) begin
                        if (r_lives == 2'd0) begin
                            r_state     <= ST_GAME_OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state   <= ST_PLAY;
                            r_respawn <= 1'b1;
                            r_freeze  <= 1'b0;
                        end
                    end
                end
                ST_LEVEL_UP: begin
                    if (w_timer_done) begin
                        r_state   <= ST_PLAY;
                        r_respawn <= 1'b1;
                        r_freeze  <= 1'b0;
                    end
                end
                // NOTE: the default item catches the unused codes 5-7 and
                // steers them back to IDLE instead of leaving them stuck.
                default: begin
                    r_state     <= ST_IDLE;
                    r_freeze    <= 1'b1;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign o_State     = r_state;
    assign o_Lives     = r_lives;
    assign o_Level     = r_level;
    assign o_Respawn   = r_respawn;
    assign o_Freeze    = r_freeze;
    assign o_Game_Over = r_game_over;

endmodule

// File: tb/tb_frogger_game_state.sv
// -----------------------------------------------------------------------------
// tb_frogger_game_state
// Directed bench for frogger_game_state with c_DEATH_FRAMES=4, c_MAX_LEVEL=9.
// Each step drives inputs, queues the outputs expected after the next edge,
// then pops and compares them 1 time unit after that edge.
// -----------------------------------------------------------------------------
module tb_frogger_game_state;
    import frogger_game_state_pkg::*;

    localparam int unsigned DEATH_FRAMES = 4;
    localparam int unsigned MAX_LEVEL    = 9;
    localparam logic [5:0]  Y_MID        = 6'd10;
    localparam logic [5:0]  Y_GOAL       = 6'd0;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Frame_Tick = 1'b0;
    logic       i_Start = 1'b0;
    logic       i_Collided = 1'b0;
    logic [5:0] i_Frogger_Y = Y_MID;
    logic [2:0] o_State;
    logic [1:0] o_Lives;
    logic [3:0] o_Level;
    logic       o_Respawn;
    logic       o_Freeze;
    logic       o_Game_Over;

    frogger_game_state #(
        .c_LIVES        (3),
        .c_DEATH_FRAMES (DEATH_FRAMES),
        .c_GOAL_ROW     (0),
        .c_MAX_LEVEL    (MAX_LEVEL)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Frame_Tick (i_Frame_Tick),
        .i_Start      (i_Start),
        .i_Collided   (i_Collided),
        .i_Frogger_Y  (i_Frogger_Y),
        .o_State      (o_State),
        .o_Lives      (o_Lives),
        .o_Level      (o_Level),
        .o_Respawn    (o_Respawn),
        .o_Freeze     (o_Freeze),
        .o_Game_Over  (o_Game_Over)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct packed {
        logic [2:0] state;
        logic [1:0] lives;
        logic [3:0] level;
        logic       respawn;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input state_t s, input int lives, input int level,
                                input logic resp);
        exp_t e;
        e.state   = s;
        e.lives   = 2'(lives);
        e.level   = 4'(level);
        e.respawn = resp;
        return e;
    endfunction

    task automatic compare();
        exp_t  e;
        string t;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed 0 expected 1");
        end else begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check({t, ":state"},     8'(o_State),     8'(e.state));
            check({t, ":lives"},     8'(o_Lives),     8'(e.lives));
            check({t, ":level"},     8'(o_Level),     8'(e.level));
            check({t, ":respawn"},   8'(o_Respawn),   8'(e.respawn));
            check({t, ":freeze"},    8'(o_Freeze),    8'(e.state != ST_PLAY));
            check({t, ":game_over"}, 8'(o_Game_Over), 8'(e.state == ST_GAME_OVER));
        end
    endtask

    task automatic step(input logic rst, input logic start, input logic coll,
                        input logic tick, input logic [5:0] y,
                        input exp_t e, input string tag);
        i_Reset      = rst;
        i_Start      = start;
        i_Collided   = coll;
        i_Frame_Tick = tick;
        i_Frogger_Y  = y;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge i_Clk);
        #1;
        compare();
    endtask

    initial begin
        int lvl;

        // Reset with start and tick pulses present: both must be dropped.
        step(1, 1, 0, 1, Y_MID, mk(ST_IDLE, 3, 0, 0), "reset");
        step(0, 0, 0, 0, Y_MID, mk(ST_IDLE, 3, 0, 0), "idle_hold");
        step(0, 1, 0, 0, Y_MID, mk(ST_PLAY, 3, 0, 1), "start");
        step(0, 0, 0, 0, Y_MID, mk(ST_PLAY, 3, 0, 0), "respawn_end");
        step(0, 1, 0, 0, Y_MID, mk(ST_PLAY, 3, 0, 0), "start_ignored_play");

        // Collision held 5 cycles: exactly one life lost.
        for (int i = 0; i < 5; i++)
            step(0, 0, 1, 0, Y_MID, mk(ST_DYING, 2, 0, 0), "collide_hold");

        // Ticks spaced by idle cycles; start is ignored while dying.
        for (int i = 0; i < int'(DEATH_FRAMES) - 1; i++) begin
            step(0, 0, 0, 1, Y_MID, mk(ST_DYING, 2, 0, 0), "death1_tick");
            step(0, 1, 0, 0, Y_MID, mk(ST_DYING, 2, 0, 0), "start_ignored_dying");
        end
        // Collision held through the respawn: guarded for two cycles.
        step(0, 0, 1, 1, Y_MID, mk(ST_PLAY, 2, 0, 1), "death1_exit");
        step(0, 0, 1, 0, Y_MID, mk(ST_PLAY, 2, 0, 0), "guard_respawn_cycle");
        step(0, 0, 1, 0, Y_MID, mk(ST_PLAY, 2, 0, 0), "guard_next_cycle");
        step(0, 0, 1, 0, Y_MID, mk(ST_DYING, 1, 0, 0), "guard_third_cycle");

        for (int i = 0; i < int'(DEATH_FRAMES) - 1; i++)
            step(0, 0, 0, 1, Y_MID, mk(ST_DYING, 1, 0, 0), "death2_tick");
        step(0, 0, 0, 1, Y_MID, mk(ST_PLAY, 1, 0, 1), "death2_exit");
        step(0, 0, 0, 0, Y_MID, mk(ST_PLAY, 1, 0, 0), "play_a");
        step(0, 0, 0, 0, Y_MID, mk(ST_PLAY, 1, 0, 0), "play_b");

        // Goal and collision together: collision wins, level unchanged.
        step(0, 0, 1, 0, Y_GOAL, mk(ST_DYING, 0, 0, 0), "goal_and_collide");
        for (int i = 0; i < int'(DEATH_FRAMES) - 1; i++)
            step(0, 0, 0, 1, Y_MID, mk(ST_DYING, 0, 0, 0), "death3_tick");
        step(0, 0, 0, 1, Y_MID, mk(ST_GAME_OVER, 0, 0, 0), "game_over");
        step(0, 0, 1, 1, Y_MID, mk(ST_GAME_OVER, 0, 0, 0), "game_over_hold");
        step(0, 1, 0, 0, Y_MID, mk(ST_PLAY, 3, 0, 1), "restart");

        // Goal alone: LEVEL_UP until the next frame tick.
        step(0, 0, 0, 0, Y_GOAL, mk(ST_LEVEL_UP, 3, 1, 0), "goal");
        step(0, 0, 0, 0, Y_GOAL, mk(ST_LEVEL_UP, 3, 1, 0), "level_up_wait");
        step(0, 0, 0, 1, Y_MID,  mk(ST_PLAY, 3, 1, 1), "level_up_exit");

        // Eleven more goals: level saturates at MAX_LEVEL.
        lvl = 1;
        for (int i = 0; i < 11; i++) begin
            lvl = (lvl < int'(MAX_LEVEL)) ? lvl + 1 : lvl;
            step(0, 0, 0, 0, Y_GOAL, mk(ST_LEVEL_UP, 3, lvl, 0), "goal_repeat");
            step(0, 0, 0, 1, Y_MID,  mk(ST_PLAY, 3, lvl, 1), "goal_repeat_exit");
        end
        check("level_saturated", 8'(o_Level), 8'(MAX_LEVEL));

        // Reset in the middle of a death pause.
        step(0, 0, 0, 0, Y_MID, mk(ST_PLAY, 3, 9, 0), "pre_death_a");
        step(0, 0, 0, 0, Y_MID, mk(ST_PLAY, 3, 9, 0), "pre_death_b");
        step(0, 0, 1, 0, Y_MID, mk(ST_DYING, 2, 9, 0), "death4");
        step(0, 0, 0, 1, Y_MID, mk(ST_DYING, 2, 9, 0), "death4_tick");
        step(1, 1, 0, 1, Y_MID, mk(ST_IDLE, 3, 0, 0), "reset_mid_dying");
        step(0, 0, 0, 0, Y_MID, mk(ST_IDLE, 3, 0, 0), "idle_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
